// File: rtl/fifo_burst_rd_ctrl.sv
// Read-side burst sequencer: waits for a full burst in the pixel FIFO, issues a beat-addressed
// command, then drains BURST_LEN words through a 4-entry skid buffer. Optional statistics: FIFO_BURST_RD_STAT_EN.
module fifo_burst_rd_ctrl #(
  parameter int DATA_WIDTH  = 24,
  parameter int LEVEL_WIDTH = 13,
  parameter int BURST_LEN   = 64,
  parameter int FRAME_BEATS = 2073600,
  parameter int ADDR_WIDTH  = 22,
  parameter int RD_LAT      = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   frame_sync,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_level,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [ADDR_WIDTH-1:0]  cmd_addr,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [DATA_WIDTH-1:0]  dout_data,
  output logic                   dout_last,
  output logic                   busy
`ifdef FIFO_BURST_RD_STAT_EN
  ,
  output logic [31:0]            stat_bursts,
  output logic [31:0]            stat_stall
`endif
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0]       BURST_CNT = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]       LAST_IDX  = CNT_W'(BURST_LEN - 1);
  localparam logic [LEVEL_WIDTH-1:0] BURST_LVL = LEVEL_WIDTH'(BURST_LEN);
  localparam logic [ADDR_WIDTH:0]    ADDR_STEP = (ADDR_WIDTH+1)'(BURST_LEN);
  localparam logic [ADDR_WIDTH:0]    ADDR_WRAP = (ADDR_WIDTH+1)'(FRAME_BEATS);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    XFER
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   addr_inc;
  logic [ADDR_WIDTH-1:0] addr_step_nxt;
  logic                  sync_pend;
  logic [CNT_W-1:0]      issued;
  logic [CNT_W-1:0]      accepted;

  logic                  rd_vld_p0;
  logic                  rd_vld_p1;
  logic [2:0]            in_flight;
  logic [2:0]            occupancy;

  logic [DATA_WIDTH-1:0] skid_mem [4];
  logic [1:0]            skid_wr;
  logic [1:0]            skid_rd;
  logic [2:0]            skid_cnt;
  logic                  skid_push;
  logic                  skid_pop;

  logic                  burst_start;
  logic                  burst_done;

  // Read issue: occupancy bounds reads so the skid buffer can never overflow
  assign in_flight  = {2'b00, rd_vld_p0} + {2'b00, rd_vld_p1};
  assign occupancy  = skid_cnt + in_flight;
  assign fifo_rd_en = (state == XFER) && !fifo_rd_empty && (issued != BURST_CNT)
                      && (occupancy < 3'd4);

  assign skid_push  = (RD_LAT == 2) ? rd_vld_p1 : rd_vld_p0;
  assign dout_valid = (skid_cnt != 3'd0);
  assign skid_pop   = dout_valid && dout_ready;
  assign dout_data  = dout_valid ? skid_mem[skid_rd] : '0;
  assign dout_last  = dout_valid && (accepted == LAST_IDX);
  assign burst_done = skid_pop && (accepted == LAST_IDX);

  assign cmd_valid  = (state == CMD);
  assign busy       = (state != IDLE);

  assign addr_inc      = {1'b0, addr} + ADDR_STEP;
  assign addr_step_nxt = (addr_inc == ADDR_WRAP) ? '0 : addr_inc[ADDR_WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable && (fifo_rd_level >= BURST_LVL)) state_nxt = CMD;
      CMD:  if (cmd_valid && cmd_ready) state_nxt = XFER;
      XFER: if (burst_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign burst_start = (state == IDLE) && (state_nxt == CMD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Address and command: a frame_sync during a burst is deferred to its end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      cmd_addr  <= '0;
      sync_pend <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (frame_sync) addr <= '0;
      end else if (frame_sync) begin
        sync_pend <= 1'b1;
      end
      if (burst_start) cmd_addr <= frame_sync ? '0 : addr;
      if (burst_done) begin
        addr      <= (sync_pend || frame_sync) ? '0 : addr_step_nxt;
        sync_pend <= 1'b0;
      end
    end
  end

  // Stage p0/p1: read-valid pipeline matching the FIFO read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p0 <= 1'b0;
      rd_vld_p1 <= 1'b0;
      issued    <= '0;
      accepted  <= '0;
    end else begin
      rd_vld_p0 <= fifo_rd_en;
      rd_vld_p1 <= (RD_LAT == 2) ? rd_vld_p0 : 1'b0;
      if (burst_done)      issued <= '0;
      else if (fifo_rd_en) issued <= issued + CNT_W'(1);
      if (skid_pop) accepted <= burst_done ? '0 : accepted + CNT_W'(1);
    end
  end

  // Skid buffer: captures returning read data, drains into the stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_wr  <= 2'd0;
      skid_rd  <= 2'd0;
      skid_cnt <= 3'd0;
    end else begin
      if (skid_push) skid_wr <= skid_wr + 2'd1;
      if (skid_pop)  skid_rd <= skid_rd + 2'd1;
      case ({skid_push, skid_pop})
        2'b10:   skid_cnt <= skid_cnt + 3'd1;
        2'b01:   skid_cnt <= skid_cnt - 3'd1;
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (skid_push) skid_mem[skid_wr] <= fifo_rd_data;
  end

`ifdef FIFO_BURST_RD_STAT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic stall_cyc;
  assign stall_cyc = (state == XFER) && fifo_rd_empty && (issued != BURST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_bursts <= 32'd0;
      stat_stall  <= 32'd0;
    end else begin
      if (burst_done) stat_bursts <= sat_inc(stat_bursts);
      if (stall_cyc)  stat_stall  <= sat_inc(stat_stall);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
// Directed bench for fifo_burst_rd_ctrl: FIFO model, stream collector and linear check sequence.
// Statistics checks are compiled in when FIFO_BURST_RD_STAT_EN is defined.
module tb_fifo_burst_rd_ctrl;
  localparam int DW = 24;
  localparam int LW = 13;
  localparam int BL = 64;
  localparam int FB = 256;
  localparam int AW = 22;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          rst_n, enable, frame_sync, cmd_ready, dout_ready;
  logic          fifo_rd_en, fifo_rd_empty, cmd_valid, dout_valid, dout_last, busy;
  logic [DW-1:0] fifo_rd_data = '0;
  logic [DW-1:0] dout_data;
  logic [LW-1:0] fifo_rd_level;
  logic [AW-1:0] cmd_addr;
`ifdef FIFO_BURST_RD_STAT_EN
  logic [31:0]   stat_bursts, stat_stall;
`endif

  fifo_burst_rd_ctrl #(
    .DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .BURST_LEN(BL),
    .FRAME_BEATS(FB), .ADDR_WIDTH(AW), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_sync(frame_sync),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .fifo_rd_level(fifo_rd_level),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_last(dout_last), .busy(busy)
`ifdef FIFO_BURST_RD_STAT_EN
    , .stat_bursts(stat_bursts), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: words pushed by the sequence, popped with one cycle read latency
  logic [DW-1:0] fmem [0:4095];
  int            wr_idx = 0;
  int            rd_idx = 0;
  logic          force_empty = 1'b0;

  assign fifo_rd_level = LW'(wr_idx - rd_idx);
  assign fifo_rd_empty = (wr_idx == rd_idx) || force_empty;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= fmem[rd_idx[11:0]];
      rd_idx       <= rd_idx + 1;
    end
  end

  // Collector: observes handshakes between edges
  int            cyc = 0, data_err = 0, occ_err = 0, rd_empty_err = 0, rd_state_err = 0;
  int            hold_err = 0, issue_err = 0, burst_beats = 0, last_beats = 0;
  int            first_cyc = 0, span = 0, bursts_done = 0, exp_idx = 0;
  int            rd_cnt = 0, acc_cnt = 0, max_occ = 0, ncmd = 0;
  logic [AW-1:0] cmd_log [0:15];
  logic          hold_prev = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic          hold_last = 1'b0;
  logic          resync = 1'b1;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (resync) begin
      burst_beats <= 0;
      rd_cnt      <= 0;
      acc_cnt     <= 0;
      exp_idx     <= rd_idx;
      hold_prev   <= 1'b0;
    end else begin
      if (fifo_rd_en) begin
        if (fifo_rd_empty)        rd_empty_err <= rd_empty_err + 1;
        if (!busy || cmd_valid)   rd_state_err <= rd_state_err + 1;
        if (rd_cnt - acc_cnt >= 4) occ_err    <= occ_err + 1;
        if (rd_cnt >= BL)         issue_err    <= issue_err + 1;
      end
      if (rd_cnt - acc_cnt > max_occ) max_occ <= rd_cnt - acc_cnt;
      if (hold_prev && !(dout_valid && dout_data === hold_data && dout_last === hold_last))
        hold_err <= hold_err + 1;
      hold_prev <= dout_valid && !dout_ready;
      hold_data <= dout_data;
      hold_last <= dout_last;
      if (cmd_valid && cmd_ready) begin
        cmd_log[ncmd[3:0]] <= cmd_addr;
        ncmd <= ncmd + 1;
      end
      if (dout_valid && dout_ready) begin
        if (burst_beats == 0) first_cyc <= cyc;
        if (dout_data !== fmem[exp_idx[11:0]]) data_err <= data_err + 1;
        exp_idx <= exp_idx + 1;
        if (dout_last) begin
          last_beats  <= burst_beats + 1;
          span        <= cyc - first_cyc;
          bursts_done <= bursts_done + 1;
          burst_beats <= 0;
          rd_cnt      <= 0;
          acc_cnt     <= 0;
        end else begin
          burst_beats <= burst_beats + 1;
          acc_cnt     <= acc_cnt + 1;
          rd_cnt      <= rd_cnt + (fifo_rd_en ? 1 : 0);
        end
      end else if (fifo_rd_en) begin
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  int n_pass = 0, n_fail = 0, n_total = 0;
  logic rnd_ready = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (failure #%0d)", tag, obs, expv, n_fail);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input int limit, input string tag);
    int n = 0;
    while (bursts_done < target && n < limit) begin
      tick();
      n++;
      if (rnd_ready) dout_ready = 1'($urandom_range(0, 1));
    end
    chk({tag, "_done"}, 64'(bursts_done >= target), 64'(1));
  endtask

  task automatic wait_beats(input int nb, input string tag);
    int n = 0;
    while (burst_beats < nb && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_reach"}, 64'(burst_beats >= nb), 64'(1));
  endtask

  int bad;
  logic [AW-1:0] exp_addr [0:9];

  initial begin
    for (int i = 0; i < 4096; i++) fmem[i] = DW'(i * 32'h0001_3579 + 32'h0000_00A5);
    exp_addr[0] = 0;   exp_addr[1] = 64;  exp_addr[2] = 128; exp_addr[3] = 192;
    exp_addr[4] = 0;   exp_addr[5] = 64;  exp_addr[6] = 128; exp_addr[7] = 0;
    exp_addr[8] = 64;  exp_addr[9] = 0;
    rst_n = 1'b0; enable = 1'b0; frame_sync = 1'b0; cmd_ready = 1'b0; dout_ready = 1'b0;
    repeat (3) tick();
    chk("rst_ctrl_outs", 64'({fifo_rd_en, cmd_valid, dout_valid, dout_last, busy}), 64'(0));
    chk("rst_cmd_addr", 64'(cmd_addr), 64'(0));
    chk("rst_dout_data", 64'(dout_data), 64'(0));

    rst_n = 1'b1; resync = 1'b0; enable = 1'b1; wr_idx = 63;
    repeat (5) tick();
    chk("lvl63_no_cmd", 64'(cmd_valid), 64'(0));
    chk("lvl63_idle", 64'(busy), 64'(0));
    wr_idx = 64;
    tick();
    chk("lvl64_cmd_valid", 64'(cmd_valid), 64'(1));
    chk("lvl64_cmd_addr", 64'(cmd_addr), 64'(0));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cmd_valid !== 1'b1 || cmd_addr !== '0 || fifo_rd_en !== 1'b0) bad++;
    end
    chk("cmd_hold_stable", 64'(bad), 64'(0));

    // Burst 1: steady ready, back-to-back beats
    cmd_ready = 1'b1; dout_ready = 1'b1;
    wait_done(1, 300, "b1");
    chk("b1_idle_after", 64'(busy), 64'(0));
    chk("b1_beats", 64'(last_beats), 64'(64));
    chk("b1_span", 64'(span), 64'(63));
    chk("b1_data", 64'(data_err), 64'(0));

    // Burst 2: stalled then random backpressure
    dout_ready = 1'b0; wr_idx = 128;
    repeat (12) tick();
    rnd_ready = 1'b1;
    wait_done(2, 1000, "b2");
    rnd_ready = 1'b0; dout_ready = 1'b1;
    chk("b2_beats", 64'(last_beats), 64'(64));
    chk("b2_data", 64'(data_err), 64'(0));
    chk("b2_max_occ", 64'(max_occ), 64'(4));
    chk("b2_occ_err", 64'(occ_err), 64'(0));
    chk("b2_hold_err", 64'(hold_err), 64'(0));

    // Burst 3: FIFO empty for 5 cycles at beat 20
`ifdef FIFO_BURST_RD_STAT_EN
    chk("stat_stall_pre", 64'(stat_stall), 64'(0));
    chk("stat_bursts_2", 64'(stat_bursts), 64'(2));
`endif
    wr_idx = 192;
    wait_beats(20, "b3_beat20");
    force_empty = 1'b1;
    repeat (5) tick();
    force_empty = 1'b0;
    wait_done(3, 300, "b3");
    chk("b3_beats", 64'(last_beats), 64'(64));
    chk("b3_data", 64'(data_err), 64'(0));
`ifdef FIFO_BURST_RD_STAT_EN
    chk("stat_stall_5", 64'(stat_stall), 64'(5));
    chk("stat_bursts_3", 64'(stat_bursts), 64'(3));
`endif

    // Bursts 4..6: address walks to the frame end and wraps
    wr_idx = 256;
    wait_done(4, 300, "b4");
    chk("b4_span", 64'(span), 64'(63));
    wr_idx = 320;
    wait_done(5, 300, "b5");
    wr_idx = 384;
    wait_done(6, 300, "b6");
    chk("b6_beats", 64'(last_beats), 64'(64));

    // Burst 7: two frame_sync pulses mid-burst collapse into one restart
    wr_idx = 448;
    wait_beats(10, "b7_beat10");
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    tick(); tick();
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    wait_done(7, 300, "b7");
    wr_idx = 512;
    wait_done(8, 300, "b8");
    chk("b8_data", 64'(data_err), 64'(0));

    // Burst 9: reset mid-transfer, burst 10 restarts at address 0
    wr_idx = 576;
    wait_beats(10, "b9_beat10");
    rst_n = 1'b0; resync = 1'b1;
    #1;
    chk("mid_rst_ctrl_outs", 64'({fifo_rd_en, cmd_valid, dout_valid, dout_last, busy}), 64'(0));
    chk("mid_rst_cmd_addr", 64'(cmd_addr), 64'(0));
    chk("mid_rst_dout_data", 64'(dout_data), 64'(0));
`ifdef FIFO_BURST_RD_STAT_EN
    chk("mid_rst_stat_bursts", 64'(stat_bursts), 64'(0));
    chk("mid_rst_stat_stall", 64'(stat_stall), 64'(0));
`endif
    tick(); tick();
    rst_n = 1'b1; resync = 1'b0;
    wr_idx = rd_idx + 64;
    wait_done(9, 300, "b10");
    chk("b10_beats", 64'(last_beats), 64'(64));
    chk("b10_data", 64'(data_err), 64'(0));
`ifdef FIFO_BURST_RD_STAT_EN
    chk("stat_bursts_after_rst", 64'(stat_bursts), 64'(1));
    chk("stat_stall_after_rst", 64'(stat_stall), 64'(0));
`endif

    chk("cmd_count", 64'(ncmd), 64'(10));
    for (int i = 0; i < 10; i++)
      chk($sformatf("cmd_addr_%0d", i), 64'(cmd_log[i]), 64'(exp_addr[i]));
    chk("rd_en_while_empty", 64'(rd_empty_err), 64'(0));
    chk("rd_en_outside_xfer", 64'(rd_state_err), 64'(0));
    chk("rd_issue_over", 64'(issue_err), 64'(0));
    chk("occupancy_over", 64'(occ_err), 64'(0));
    chk("hold_violations", 64'(hold_err), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
